mem_bist: RTL and testbench
===========================

MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 Parameter DW, default 32, data width of the SRAM port.
REQ-002 Parameter AW, default 16, address width of the SRAM port.
REQ-003 mclk  in  1  the single clock; all logic on its rising edge.
REQ-004 mrst  in  1  reset, asynchronous and active-high.
REQ-005 i_start  in  1  one-cycle start pulse; sampled only in IDLE or DONE.
REQ-006 i_pattern  in  DW  background pattern P, latched at start.
REQ-007 i_last_addr  in  AW  highest address tested, latched at start; N = i_last_addr+1.
REQ-008 o_csn  out  1  SRAM chip select, active-low.
REQ-009 o_wr  out  1  SRAM write enable; 1=write, 0=read, valid when o_csn=0.
REQ-010 o_addr  out  AW  SRAM address.
REQ-011 o_wdata  out  DW  SRAM write data.
REQ-012 i_rdata  in  DW  SRAM read data, valid the cycle after a read access.
REQ-013 o_busy  out  1  test in progress.
REQ-014 o_done  out  1  test complete; held until next accepted start or reset.
REQ-015 o_fail  out  1  sticky; at least one mismatch this run.
REQ-016 o_fail_addr  out  AW  address of first mismatch.
REQ-017 o_fail_data  out  DW  i_rdata captured at first mismatch.
REQ-018 o_err_cnt  out  16  mismatch count, saturating at 16'hFFFF.

Function
REQ-019 States: IDLE, W0, R0W1_RD, R0W1_WR, R1, DRAIN, DONE; all SRAM outputs registered.
REQ-020 IDLE/DONE + i_start=1: latch P and i_last_addr, clear o_fail/o_err_cnt/o_fail_*, clear o_done, go W0 with o_addr=0.
REQ-021 W0: each cycle o_csn=0, o_wr=1, o_wdata=P, address ascending; at o_addr==last go R0W1_RD with o_addr=0.
REQ-022 R0W1_RD: o_csn=0, o_wr=0 at current address; next state R0W1_WR, same address.
REQ-023 R0W1_WR: o_csn=0, o_wr=1, o_wdata=~P; compare i_rdata against P this cycle; at last address go R1 with o_addr=last, else R0W1_RD at address+1.
REQ-024 R1: one read per cycle, address descending, expected ~P; compare each read's i_rdata one cycle later; after reading address 0 go DRAIN.
REQ-025 DRAIN: o_csn=1; final R1 compare occurs; next state DONE.
REQ-026 DONE: o_done=1, o_busy=0, o_csn=1; o_fail/o_err_cnt/o_fail_* hold.
REQ-027 o_busy=1 in every state except IDLE and DONE.
REQ-028 Latency: o_done rises 4N+1 rising edges after the edge sampling i_start.
REQ-029 Compare pipeline carries expected data and address one stage behind the read access.
REQ-030 Mismatch: o_err_cnt+1 (saturating), o_fail=1; o_fail_addr/o_fail_data loaded only when o_fail was 0.
REQ-031 Outside access states o_csn=1; o_wr/o_addr/o_wdata hold last values.
REQ-032 i_start while o_busy=1 is ignored.
REQ-033 i_last_addr=0: single-address run, 5 cycles to o_done.
REQ-034 i_last_addr=all-ones: termination by equality compare, never by counter overflow; no address wrap.

Reset
REQ-035 mrst=1 at any time, including mid-test: state=IDLE, o_csn=1, o_wr=0, o_addr=0, o_wdata=0, o_busy=0, o_done=0, o_fail=0, o_fail_addr=0, o_fail_data=0, o_err_cnt=0, compare pipeline cleared.
REQ-036 The first cycle after reset release performs no SRAM access.

Structure
REQ-037 State encodings and the 16-bit error-counter width live in the shared package mem_bist_pkg.
REQ-038 Compare and error logging is sub-module mem_bist_cmp (inputs: valid, expected, rdata, addr; outputs: fail, fail_addr, fail_data, err_cnt).

Verification
REQ-039 Bench: mem_bist driving the spsram model with mclk at 10 ns; mrst released at 100 ns.
REQ-040 P=32'hA5A5_5A5A, last=15, clean SRAM -> o_done at edge 65, o_fail=0, o_err_cnt=0, SRAM reads back ~P at all 16 words.
REQ-041 Same run with SRAM bit 0 of address 7 forced to 1 -> o_fail=1, o_fail_addr=7, o_fail_data=32'hA5A5_5A5B, o_err_cnt=1.
REQ-042 last=0, P=0 -> o_done 5 edges after start; access trace W@0, R@0, W@0, R@0.
REQ-043 Start pulse at cycle 10 of a busy run -> ignored; completion time unchanged.
REQ-044 mrst pulsed mid-R0W1 -> all outputs at reset values asynchronously; a new start runs a full clean test.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the March-style SRAM BIST.
package mem_bist_pkg;

  localparam int unsigned ERR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_W0      = 3'd1,
    ST_R0W1_RD = 3'd2,
    ST_R0W1_WR = 3'd3,
    ST_R1      = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Increment that sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data comparator with sticky first-failure capture and saturating error count.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [DW-1:0]    expected_i,
  input  logic [DW-1:0]    rdata_i,
  input  logic [AW-1:0]    addr_i,
  output logic             fail_o,
  output logic [AW-1:0]    fail_addr_o,
  output logic [DW-1:0]    fail_data_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  logic             fail_q;
  logic [AW-1:0]    fail_addr_q;
  logic [DW-1:0]    fail_data_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             mismatch_d;

  assign mismatch_d = valid_i && (rdata_i != expected_i);

  // Log mismatches; the first one of a run freezes address and data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_cnt_q   <= '0;
    end else if (clr_i) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      err_cnt_q   <= '0;
    end else if (mismatch_d) begin
      fail_q    <= 1'b1;
      err_cnt_q <= sat_inc(err_cnt_q);
      if (!fail_q) begin
        fail_addr_q <= addr_i;
        fail_data_q <= rdata_i;
      end
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/mem_bist.sv
// SRAM BIST: write P ascending, read-P/write-~P ascending, read ~P descending.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 16
) (
  input  logic             mclk,
  input  logic             mrst,
  input  logic             i_start,
  input  logic [DW-1:0]    i_pattern,
  input  logic [AW-1:0]    i_last_addr,
  output logic             o_csn,
  output logic             o_wr,
  output logic [AW-1:0]    o_addr,
  output logic [DW-1:0]    o_wdata,
  input  logic [DW-1:0]    i_rdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_fail,
  output logic [AW-1:0]    o_fail_addr,
  output logic [DW-1:0]    o_fail_data,
  output logic [ERR_W-1:0] o_err_cnt
);

  state_e        state_q;
  logic          csn_q, wr_q, busy_q, done_q;
  logic [AW-1:0] addr_q, last_q;
  logic [DW-1:0] wdata_q, pat_q;

  logic          pv_q, pv_d;
  logic [DW-1:0] pexp_q, pexp_d;
  logic [AW-1:0] paddr_q;
  logic          start_acc_d;

  assign start_acc_d = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && i_start;
  assign pv_d        = !csn_q && !wr_q;
  assign pexp_d      = (state_q == ST_R1) ? ~pat_q : pat_q;

  // Sequencer: every SRAM strobe is a register written here.
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      state_q <= ST_IDLE;
      csn_q   <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pat_q   <= '0;
      last_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            pat_q   <= i_pattern;
            last_q  <= i_last_addr;
            state_q <= ST_W0;
            csn_q   <= 1'b0;
            wr_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= i_pattern;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_W0: begin
          if (addr_q == last_q) begin
            state_q <= ST_R0W1_RD;
            addr_q  <= '0;
            wr_q    <= 1'b0;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        ST_R0W1_RD: begin
          state_q <= ST_R0W1_WR;
          wr_q    <= 1'b1;
          wdata_q <= ~pat_q;
        end
        ST_R0W1_WR: begin
          wr_q <= 1'b0;
          if (addr_q == last_q) begin
            state_q <= ST_R1;
          end else begin
            state_q <= ST_R0W1_RD;
            addr_q  <= addr_q + AW'(1);
          end
        end
        ST_R1: begin
          if (addr_q == '0) begin
            state_q <= ST_DRAIN;
            csn_q   <= 1'b1;
          end else begin
            addr_q <= addr_q - AW'(1);
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          csn_q   <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Compare pipeline: expected data and address trail each read by one cycle.
  always_ff @(posedge mclk or posedge mrst) begin
    if (mrst) begin
      pv_q    <= 1'b0;
      pexp_q  <= '0;
      paddr_q <= '0;
    end else begin
      pv_q    <= pv_d;
      pexp_q  <= pexp_d;
      paddr_q <= addr_q;
    end
  end

  mem_bist_cmp #(.DW(DW), .AW(AW)) u_cmp (
    .clk_i       (mclk),
    .rst_i       (mrst),
    .clr_i       (start_acc_d),
    .valid_i     (pv_q),
    .expected_i  (pexp_q),
    .rdata_i     (i_rdata),
    .addr_i      (paddr_q),
    .fail_o      (o_fail),
    .fail_addr_o (o_fail_addr),
    .fail_data_o (o_fail_data),
    .err_cnt_o   (o_err_cnt)
  );

  assign o_csn   = csn_q;
  assign o_wr    = wr_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: SRAM model, access-trace model and directed runs.
module tb_mem_bist;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;

  logic          mclk;
  logic          mrst;
  logic          i_start;
  logic [DW-1:0] i_pattern;
  logic [AW-1:0] i_last_addr;
  logic          o_csn, o_wr, o_busy, o_done, o_fail;
  logic [AW-1:0] o_addr, o_fail_addr;
  logic [DW-1:0] o_wdata, o_fail_data;
  logic [DW-1:0] i_rdata;
  logic [15:0]   o_err_cnt;

  mem_bist #(.DW(DW), .AW(AW)) dut (
    .mclk        (mclk),
    .mrst        (mrst),
    .i_start     (i_start),
    .i_pattern   (i_pattern),
    .i_last_addr (i_last_addr),
    .o_csn       (o_csn),
    .o_wr        (o_wr),
    .o_addr      (o_addr),
    .o_wdata     (o_wdata),
    .i_rdata     (i_rdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_fail      (o_fail),
    .o_fail_addr (o_fail_addr),
    .o_fail_data (o_fail_data),
    .o_err_cnt   (o_err_cnt)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  // Single-port SRAM with an optional stuck-at-1 on bit 0 of one word.
  logic [DW-1:0] mem [0:255];
  logic          stuck_en;
  logic [AW-1:0] stuck_addr;
  always @(posedge mclk) begin
    if (!o_csn) begin
      if (o_wr) mem[o_addr[7:0]] <= o_wdata;
      else      i_rdata <= mem[o_addr[7:0]] |
                           ((stuck_en && (o_addr == stuck_addr)) ? 32'h1 : 32'h0);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected run: access list in order plus predicted logging outcome.
  logic          exp_wr   [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic          act_wr   [$];
  logic [AW-1:0] act_addr [$];
  int            n_words;
  logic          exp_fail;
  logic [AW-1:0] exp_faddr;
  logic [DW-1:0] exp_fdata;
  int            exp_err;
  bit            model_on = 1'b0;
  int            start_cyc = 0;

  task automatic model_read(input int a, input logic [DW-1:0] expv);
    logic [DW-1:0] got;
    got = expv | ((stuck_en && (AW'(a) == stuck_addr)) ? 32'h1 : 32'h0);
    if (got != expv) begin
      exp_err++;
      if (!exp_fail) begin
        exp_fail  = 1'b1;
        exp_faddr = AW'(a);
        exp_fdata = got;
      end
    end
  endtask

  task automatic build_model(input logic [DW-1:0] p, input int last);
    exp_wr.delete(); exp_addr.delete(); exp_data.delete();
    n_words = last + 1;
    exp_fail = 1'b0; exp_faddr = '0; exp_fdata = '0; exp_err = 0;
    for (int a = 0; a <= last; a++) begin
      exp_wr.push_back(1'b1); exp_addr.push_back(AW'(a)); exp_data.push_back(p);
    end
    for (int a = 0; a <= last; a++) begin
      exp_wr.push_back(1'b0); exp_addr.push_back(AW'(a)); exp_data.push_back('0);
      model_read(a, p);
      exp_wr.push_back(1'b1); exp_addr.push_back(AW'(a)); exp_data.push_back(~p);
    end
    for (int a = last; a >= 0; a--) begin
      exp_wr.push_back(1'b0); exp_addr.push_back(AW'(a)); exp_data.push_back('0);
      model_read(a, ~p);
    end
  endtask

  // One cycle: advance to the falling edge and compare against the model.
  task automatic tick();
    int kk;
    @(negedge mclk);
    if (model_on && !mrst) begin
      kk = cyc - start_cyc;
      if (kk == 0) begin act_wr.delete(); act_addr.delete(); end
      if (kk < 4*n_words) begin
        act_wr.push_back(o_wr); act_addr.push_back(o_addr);
        chk("csn_access", 64'(o_csn), 64'(0));
        chk("wr", 64'(o_wr), 64'(exp_wr[kk]));
        chk("addr", 64'(o_addr), 64'(exp_addr[kk]));
        if (exp_wr[kk]) chk("wdata", 64'(o_wdata), 64'(exp_data[kk]));
      end else begin
        chk("csn_quiet", 64'(o_csn), 64'(1));
      end
      chk("busy", 64'(o_busy), 64'(kk <= 4*n_words));
      chk("done", 64'(o_done), 64'(kk >= 4*n_words + 1));
    end
  endtask

  task automatic start_run(input logic [DW-1:0] p, input int last);
    tick();
    i_pattern   = p;
    i_last_addr = AW'(last);
    i_start     = 1'b1;
    build_model(p, last);
    @(posedge mclk);
    #1;
    i_start   = 1'b0;
    start_cyc = cyc;
    model_on  = 1'b1;
  endtask

  task automatic run_full(input logic [DW-1:0] p, input int last, input int exp_edge, input bit ign);
    bit seen;
    seen = 1'b0;
    start_run(p, last);
    for (int c = 0; c < 400 && !seen; c++) begin
      tick();
      i_start = ign && ((cyc - start_cyc) == 10);
      if (o_done) seen = 1'b1;
    end
    i_start = 1'b0;
    chk("done_seen", 64'(seen), 64'(1));
    chk("done_edge", 64'(cyc - start_cyc), 64'(exp_edge));
    chk("fail", 64'(o_fail), 64'(exp_fail));
    chk("err_cnt", 64'(o_err_cnt), 64'(exp_err));
    chk("fail_addr", 64'(o_fail_addr), 64'(exp_faddr));
    chk("fail_data", 64'(o_fail_data), 64'(exp_fdata));
    repeat (3) tick();
    model_on = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_csn"}, 64'(o_csn), 64'(1));
    chk({tag, "_wr"}, 64'(o_wr), 64'(0));
    chk({tag, "_addr"}, 64'(o_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(o_wdata), 64'(0));
    chk({tag, "_busy"}, 64'(o_busy), 64'(0));
    chk({tag, "_done"}, 64'(o_done), 64'(0));
    chk({tag, "_fail"}, 64'(o_fail), 64'(0));
    chk({tag, "_faddr"}, 64'(o_fail_addr), 64'(0));
    chk({tag, "_fdata"}, 64'(o_fail_data), 64'(0));
    chk({tag, "_err"}, 64'(o_err_cnt), 64'(0));
  endtask

  initial begin
    logic [3:0] lit_wr;
    int         nt;
    mrst = 1'b1; i_start = 1'b0; i_pattern = '0; i_last_addr = '0;
    stuck_en = 1'b0; stuck_addr = '0;
    #50;
    chk_reset_vals("rst");
    #50;
    mrst = 1'b0;
    repeat (2) begin
      tick();
      chk("first_idle_csn", 64'(o_csn), 64'(1));
    end

    // Clean 16-word run.
    run_full(32'hA5A5_5A5A, 15, 65, 1'b0);
    chk("clean_fail", 64'(o_fail), 64'(0));
    chk("clean_err", 64'(o_err_cnt), 64'(0));
    for (int a = 0; a < 16; a++) chk("sram_readback", 64'(mem[a]), 64'(32'h5A5A_A5A5));

    // Stuck-at-1 on bit 0 of word 7.
    stuck_en = 1'b1; stuck_addr = 16'd7;
    run_full(32'hA5A5_5A5A, 15, 65, 1'b0);
    chk("stuck_fail", 64'(o_fail), 64'(1));
    chk("stuck_faddr", 64'(o_fail_addr), 64'(7));
    chk("stuck_fdata", 64'(o_fail_data), 64'(32'hA5A5_5A5B));
    chk("stuck_err", 64'(o_err_cnt), 64'(1));
    stuck_en = 1'b0;

    // Single-address run.
    run_full(32'h0, 0, 5, 1'b0);
    lit_wr = 4'b0101;
    chk("trace_len", 64'(act_wr.size()), 64'(4));
    nt = (act_wr.size() < 4) ? act_wr.size() : 4;
    for (int i = 0; i < nt; i++) begin
      chk("trace_wr", 64'(act_wr[i]), 64'(lit_wr[i]));
      chk("trace_addr", 64'(act_addr[i]), 64'(0));
    end

    // Start pulse during a busy run must not disturb it.
    run_full(32'h1234_5678, 15, 65, 1'b1);

    // Asynchronous reset in the middle of R0W1, then a fresh clean run.
    start_run(32'hA5A5_5A5A, 15);
    for (int c = 0; c < 20; c++) tick();
    #2;
    mrst = 1'b1;
    model_on = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    mrst = 1'b0;
    tick();
    chk("post_rst_csn", 64'(o_csn), 64'(1));
    run_full(32'hA5A5_5A5A, 15, 65, 1'b0);
    chk("post_rst_fail", 64'(o_fail), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
